csr_file: RTL and testbench
===========================

// Module: csr_file
// PURPOSE
//  Parametrised CSR file, successor to the FP-only CSR block. Holds fcsr (frm, sticky fflags),
//  64-bit mcycle/minstret, their user read-only shadows, and mcountinhibit. Sits in the ID/EX
//  CSR path. Accumulates FPU exception flags from N writeback lanes.
//  Flags unmapped and illegal accesses to the decoder.
// PARAMETERS
//  XLEN        32  data width; 32 or 64 only
//  CNT_W       64  counter width; 64 is the only legal value
//  FP_LANES    2   FPU writeback lanes reporting fflags
//  RETIRE_W    2   max instructions retired per cycle; i_instret_cnt is $clog2(RETIRE_W+1) bits
// PORTS
//  i_clk          in   1                 clock
//  i_rst_n        in   1                 async active-low reset
//  i_csr_addr     in   12                CSR address
//  i_csr_op       in   2                 00 RW, 01 RS, 10 RC, 11 reserved
//  i_csr_write    in   1                 write strobe (decoder already suppressed RS/RC with rs1=x0)
//  i_wr_data      in   XLEN              Reg[rs1] or zext(uimm)
//  o_rd_data      out  XLEN              combinational read of current state
//  o_illegal      out  1                 combinational illegal-access flag
//  i_fflags_vld   in   FP_LANES          per-lane flag valid
//  i_fflags       in   FP_LANES x 5      per-lane {nv,dz,of,uf,nx}
//  i_instret_cnt  in   $clog2(RETIRE_W+1) instructions retired this cycle
//  o_frm          out  3                 current frm to FPU
//  o_frm_invalid  out  1                 frm in {5,6,7}; dynamic rounding is illegal
// BEHAVIOUR
//  Reset (async): frm=0, fflags=0, mcycle=0, minstret=0, mcountinhibit=0.
//  Reset outputs: o_frm=0, o_frm_invalid=0. o_rd_data and o_illegal stay combinational.
//  Reset mid-operation clears all state immediately; no partial write survives.
//  Address map:
//   - 001 fflags, 002 frm, 003 fcsr, 320 mcountinhibit
//   - B00 mcycle, B02 minstret, B80 mcycleh, B82 minstreth
//   - C00 cycle, C02 instret, C80 cycleh, C82 instreth
//   - *h addresses exist only when XLEN=32; with XLEN=64 they are unmapped.
//  Read timing: 0-cycle combinational read. Write takes effect at the next posedge.
//  Read values:
//   - Unmapped reads return 0.
//   - mcountinhibit reads {29'b0, IR, 1'b0, CY}; bit 1 reads 0.
//  Write data: wd = RW ? i_wr_data : RS ? rd|i_wr_data : rd & ~i_wr_data.
//  o_illegal = 1 when any of:
//   - address is unmapped;
//   - i_csr_op == 11;
//   - i_csr_write=1 to a C-page address (read-only shadows).
//  When o_illegal=1, no state changes from this access. Flag accumulation and counting proceed.
//  fflags next state = base | OR over lanes of (i_fflags_vld[k] ? i_fflags[k] : 0).
//   - base = wd[4:0] if a legal write hits 001/003 this cycle, else the current fflags.
//   - A simultaneous write and raise therefore keeps the raised bits (write-then-OR).
//  frm: written by 002 (wd[2:0]) or 003 (wd[7:5]). Stored as written (no WARL remap).
//  o_frm_invalid = (frm >= 5).
//  mcycle: +1 per cycle unless CY=1.
//  minstret: +i_instret_cnt per cycle unless IR=1.
//  Counter write (XLEN=32):
//   - Low half replaced, high half preserved; mcycleh/minstreth do the opposite.
//   - That counter's increment is suppressed in the write cycle, so the written value reads back exactly.
//  Counter write (XLEN=64): full 64-bit replace; increment suppressed in the write cycle.
//  Counter width rules:
//   - Counters wrap 2^64-1 -> 0 (minstret wraps modulo 2^64 with cnt>1).
//   - Low-half carry propagates into the high half in the same cycle.
// STRUCTURE
//  Package csr_pkg holds:
//   - CSR address localparams;
//   - typedef enum logic [1:0] csr_op_e;
//   - typedef struct packed fflags_t {nv,dz,of,uf,nx};
//   - frm encodings (RNE=0 ... RMM=4, DYN=7).
//  Sub-module csr_counter (params CNT_W, INC_W):
//   - inputs: inhibit, inc, wr_lo, wr_hi, wr_full, wdata;
//   - output: value;
//   - instantiated twice (mcycle, minstret).
//  Top level holds decode, RS/RC merge, illegal logic, fcsr and mcountinhibit.
// TESTING
//  1. Reset with i_rst_n=0 -> rd of 003 = 0, o_frm=0, cycle reads 0; after 10 free cycles cycle reads 10.
//  2. Write 003 RW 0xE5 -> rd 003 = 0xE5, rd 002 = 7, rd 001 = 0x05, o_frm_invalid=1.
//     Then RC 002 with 0x4 -> frm=3, o_frm_invalid=0.
//  3. Same cycle: write 001 RW 0x01, lane0 vld fflags=0x10, lane1 vld 0x04 -> next rd 001 = 0x15.
//     Lane1 vld=0 with data 0x08 -> no effect.
//  4. XLEN=32:
//     - write mcycle=0xFFFF_FFFE, mcycleh=0 -> after 3 cycles mcycleh=1, mcycle=0x1;
//     - write to C00 -> o_illegal=1, counter unaffected.
//  5. Write 320 = 0x5 -> mcycle and minstret frozen with i_instret_cnt=2 for 5 cycles.
//     Clearing bit 0 resumes cycle only.
//  6. Read 0x7C0 or op=11 -> o_illegal=1, rd=0.
//     Assert reset during a pending RS write -> all state 0 next cycle.

Source files
------------

// File: rtl/csr_pkg.sv
// csr_pkg: CSR addresses, access op encoding, fflags layout and rounding-mode encodings
package csr_pkg;
  localparam logic [11:0] A_FFLAGS    = 12'h001;
  localparam logic [11:0] A_FRM       = 12'h002;
  localparam logic [11:0] A_FCSR      = 12'h003;
  localparam logic [11:0] A_MCNTINH   = 12'h320;
  localparam logic [11:0] A_MCYCLE    = 12'hB00;
  localparam logic [11:0] A_MINSTRET  = 12'hB02;
  localparam logic [11:0] A_MCYCLEH   = 12'hB80;
  localparam logic [11:0] A_MINSTRETH = 12'hB82;
  localparam logic [11:0] A_CYCLE     = 12'hC00;
  localparam logic [11:0] A_INSTRET   = 12'hC02;
  localparam logic [11:0] A_CYCLEH    = 12'hC80;
  localparam logic [11:0] A_INSTRETH  = 12'hC82;
  typedef enum logic [1:0] {OP_RW = 2'b00, OP_RS = 2'b01, OP_RC = 2'b10, OP_RSV = 2'b11} csr_op_e;
  typedef struct packed {
    logic nv;
    logic dz;
    logic of;
    logic uf;
    logic nx;
  } fflags_t;
  localparam logic [2:0] FRM_RNE = 3'd0;
  localparam logic [2:0] FRM_RTZ = 3'd1;
  localparam logic [2:0] FRM_RDN = 3'd2;
  localparam logic [2:0] FRM_RUP = 3'd3;
  localparam logic [2:0] FRM_RMM = 3'd4;
  localparam logic [2:0] FRM_DYN = 3'd7;
endpackage

// File: rtl/csr_file_counter.sv
// csr_counter: wrapping counter with half/full overwrite; any write suppresses that cycle's increment
module csr_counter #(
  parameter int CNT_W = 64,
  parameter int INC_W = 2
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_inhibit,
  input  logic [INC_W-1:0] i_inc,
  input  logic             i_wr_lo,
  input  logic             i_wr_hi,
  input  logic             i_wr_full,
  input  logic [CNT_W-1:0] i_wdata,
  output logic [CNT_W-1:0] o_value
);
  localparam int H = CNT_W / 2;
  logic [CNT_W-1:0] r_value;
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) r_value <= '0;
    else if (i_wr_full) r_value <= i_wdata;
    else if (i_wr_lo) r_value <= {r_value[CNT_W-1:H], i_wdata[H-1:0]};
    else if (i_wr_hi) r_value <= {i_wdata[H-1:0], r_value[H-1:0]};
    else if (!i_inhibit) r_value <= r_value + CNT_W'(i_inc);
  assign o_value = r_value;
endmodule

// File: rtl/csr_file.sv
// csr_file: fcsr, mcycle/minstret with user shadows and mcountinhibit; flags illegal accesses
module csr_file
  import csr_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int CNT_W    = 64,
  parameter int FP_LANES = 2,
  parameter int RETIRE_W = 2
) (
  input  logic                          i_clk,
  input  logic                          i_rst_n,
  input  logic [11:0]                   i_csr_addr,
  input  logic [1:0]                    i_csr_op,
  input  logic                          i_csr_write,
  input  logic [XLEN-1:0]               i_wr_data,
  output logic [XLEN-1:0]               o_rd_data,
  output logic                          o_illegal,
  input  logic [FP_LANES-1:0]           i_fflags_vld,
  input  logic [FP_LANES*5-1:0]         i_fflags,
  input  logic [$clog2(RETIRE_W+1)-1:0] i_instret_cnt,
  output logic [2:0]                    o_frm,
  output logic                          o_frm_invalid
);
  localparam int INC_W = $clog2(RETIRE_W + 1);
  localparam int H = CNT_W / 2;
  fflags_t          r_fflags;
  logic [2:0]       r_frm;
  logic             r_cy;
  logic             r_ir;
  logic [CNT_W-1:0] w_mcycle;
  logic [CNT_W-1:0] w_minstret;
  logic [XLEN-1:0]  w_rd;
  logic [XLEN-1:0]  w_wd;
  logic             w_mapped;
  logic             w_we;
  logic [4:0]       w_raise;
  logic [4:0]       w_base;
  always_comb begin
    w_rd = '0;
    w_mapped = 1'b1;
    case (i_csr_addr)
      A_FFLAGS: w_rd = XLEN'(r_fflags);
      A_FRM: w_rd = XLEN'(r_frm);
      A_FCSR: w_rd = XLEN'({r_frm, r_fflags});
      A_MCNTINH: w_rd = XLEN'({r_ir, 1'b0, r_cy});
      A_MCYCLE, A_CYCLE: w_rd = w_mcycle[XLEN-1:0];
      A_MINSTRET, A_INSTRET: w_rd = w_minstret[XLEN-1:0];
      A_MCYCLEH, A_CYCLEH: begin
        w_mapped = (XLEN == 32);
        w_rd = (XLEN == 32) ? XLEN'(w_mcycle[CNT_W-1:H]) : '0;
      end
      A_MINSTRETH, A_INSTRETH: begin
        w_mapped = (XLEN == 32);
        w_rd = (XLEN == 32) ? XLEN'(w_minstret[CNT_W-1:H]) : '0;
      end
      default: w_mapped = 1'b0;
    endcase
  end
  assign o_illegal = !w_mapped || (i_csr_op == OP_RSV) || (i_csr_write && i_csr_addr[11:8] == 4'hC);
  assign o_rd_data = (i_csr_op == OP_RSV) ? '0 : w_rd;
  assign w_we = i_csr_write && !o_illegal;
  assign w_wd = (i_csr_op == OP_RW) ? i_wr_data :
                (i_csr_op == OP_RS) ? (w_rd | i_wr_data) : (w_rd & ~i_wr_data);
  always_comb begin
    w_raise = '0;
    for (int k = 0; k < FP_LANES; k++)
      w_raise = w_raise | (i_fflags_vld[k] ? i_fflags[k*5 +: 5] : 5'b0);
  end
  // write lands first, then this cycle's raised flags are OR-ed on top
  assign w_base = (w_we && (i_csr_addr == A_FFLAGS || i_csr_addr == A_FCSR)) ? w_wd[4:0] : r_fflags;
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      r_fflags <= '0;
      r_frm <= FRM_RNE;
      r_cy <= 1'b0;
      r_ir <= 1'b0;
    end else begin
      r_fflags <= fflags_t'(w_base | w_raise);
      if (w_we && i_csr_addr == A_FRM) r_frm <= w_wd[2:0];
      if (w_we && i_csr_addr == A_FCSR) r_frm <= w_wd[7:5];
      if (w_we && i_csr_addr == A_MCNTINH) begin
        r_cy <= w_wd[0];
        r_ir <= w_wd[2];
      end
    end
  assign o_frm = r_frm;
  assign o_frm_invalid = r_frm > FRM_RMM;
  csr_counter #(.CNT_W(CNT_W), .INC_W(1)) u_mcycle (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_inhibit(r_cy), .i_inc(1'b1),
    .i_wr_lo(w_we && i_csr_addr == A_MCYCLE && XLEN == 32),
    .i_wr_hi(w_we && i_csr_addr == A_MCYCLEH),
    .i_wr_full(w_we && i_csr_addr == A_MCYCLE && XLEN != 32),
    .i_wdata(CNT_W'(w_wd)), .o_value(w_mcycle)
  );
  csr_counter #(.CNT_W(CNT_W), .INC_W(INC_W)) u_minstret (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_inhibit(r_ir), .i_inc(i_instret_cnt),
    .i_wr_lo(w_we && i_csr_addr == A_MINSTRET && XLEN == 32),
    .i_wr_hi(w_we && i_csr_addr == A_MINSTRETH),
    .i_wr_full(w_we && i_csr_addr == A_MINSTRET && XLEN != 32),
    .i_wdata(CNT_W'(w_wd)), .o_value(w_minstret)
  );
endmodule

// File: tb/tb_csr_file.sv
// tb_csr_file: directed stimulus queues expected values; a negedge monitor pops and compares them
module tb_csr_file;
  logic        i_clk = 1'b0;
  logic        i_rst_n = 1'b0;
  logic [11:0] i_csr_addr = '0;
  logic [1:0]  i_csr_op = '0;
  logic        i_csr_write = 1'b0;
  logic [31:0] i_wr_data = '0;
  logic [31:0] o_rd_data;
  logic        o_illegal;
  logic [1:0]  i_fflags_vld = '0;
  logic [9:0]  i_fflags = '0;
  logic [1:0]  i_instret_cnt = '0;
  logic [2:0]  o_frm;
  logic        o_frm_invalid;
  typedef struct {
    string       name;
    int          sel;
    logic [63:0] exp;
  } exp_t;
  exp_t q[$];
  exp_t e;
  logic [63:0] act;
  logic req = 1'b0;
  logic done = 1'b0;
  int n_chk = 0;
  int n_fail = 0;
  csr_file dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_csr_addr(i_csr_addr), .i_csr_op(i_csr_op),
    .i_csr_write(i_csr_write), .i_wr_data(i_wr_data), .o_rd_data(o_rd_data),
    .o_illegal(o_illegal), .i_fflags_vld(i_fflags_vld), .i_fflags(i_fflags),
    .i_instret_cnt(i_instret_cnt), .o_frm(o_frm), .o_frm_invalid(o_frm_invalid)
  );
  always #5 i_clk = ~i_clk;
  always @(negedge i_clk)
    if (req)
      while (q.size() > 0) begin
        e = q.pop_front();
        act = (e.sel == 0) ? {32'b0, o_rd_data} : (e.sel == 1) ? {63'b0, o_illegal} :
              (e.sel == 2) ? {61'b0, o_frm} : {63'b0, o_frm_invalid};
        n_chk++;
        if (act !== e.exp) begin
          n_fail++;
          $display("FAIL %s: got 0x%0h expected 0x%0h", e.name, act, e.exp);
        end
      end
  initial begin
    #100000;
    if (!done) begin
      n_fail++;
      $display("FAIL timeout: stimulus did not complete");
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
    end
  end
  task automatic chk(input string n, input int sel, input logic [63:0] x);
    q.push_back('{n, sel, x});
  endtask
  task automatic sample();
    req = 1'b1;
    @(posedge i_clk);
    #1 req = 1'b0;
  endtask
  task automatic rd(input logic [11:0] a, input logic [63:0] x, input string n);
    i_csr_addr = a;
    i_csr_op = 2'b00;
    i_csr_write = 1'b0;
    chk(n, 0, x);
    sample();
  endtask
  task automatic wr(input logic [11:0] a, input logic [1:0] op, input logic [31:0] d);
    i_csr_addr = a;
    i_csr_op = op;
    i_wr_data = d;
    i_csr_write = 1'b1;
    @(posedge i_clk);
    #1 i_csr_write = 1'b0;
  endtask
  initial begin
    @(posedge i_clk);
    #1;
    n_chk++;
    if (o_frm !== 3'd0 || o_frm_invalid !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_outputs: frm=%0d frm_invalid=%0b", o_frm, o_frm_invalid);
    end
    rd(12'hC00, 0, "rst_cycle");
    chk("rst_frm", 2, 0);
    rd(12'h003, 0, "rst_fcsr");
    i_rst_n = 1'b1;
    repeat (10) @(posedge i_clk);
    #1 rd(12'hC00, 10, "cycle_10");
    wr(12'h003, 2'b00, 32'hE5);
    rd(12'h003, 32'hE5, "fcsr_rw");
    chk("frm_out_7", 2, 7);
    rd(12'h002, 7, "frm_rd_7");
    chk("frm_inv_1", 3, 1);
    rd(12'h001, 5, "fflags_rd_5");
    wr(12'h002, 2'b10, 32'h4);
    chk("frm_inv_0", 3, 0);
    rd(12'h002, 3, "frm_rc");
    i_csr_addr = 12'h001; i_csr_op = 2'b00; i_wr_data = 32'h1; i_csr_write = 1'b1;
    i_fflags_vld = 2'b11; i_fflags = {5'h04, 5'h10};
    @(posedge i_clk);
    #1 i_csr_write = 1'b0; i_fflags_vld = 2'b00; i_fflags = '0;
    rd(12'h001, 32'h15, "fflags_wr_or");
    i_fflags_vld = 2'b01; i_fflags = {5'h08, 5'h02};
    @(posedge i_clk);
    #1 i_fflags_vld = 2'b00; i_fflags = '0;
    rd(12'h001, 32'h17, "fflags_lane_vld");
    wr(12'hB00, 2'b00, 32'hFFFF_FFFE);
    wr(12'hB80, 2'b00, 32'h0);
    repeat (3) @(posedge i_clk);
    #1 rd(12'hB00, 1, "mcycle_lo_carry");
    rd(12'hB80, 1, "mcycleh_carry");
    i_csr_addr = 12'hC00; i_csr_op = 2'b00; i_wr_data = 32'h0; i_csr_write = 1'b1;
    chk("cpage_wr_illegal", 1, 1);
    sample();
    i_csr_write = 1'b0;
    rd(12'hB00, 4, "cpage_wr_no_effect");
    wr(12'hB00, 2'b00, 32'd100);
    wr(12'hB02, 2'b00, 32'd50);
    i_instret_cnt = 2'd2;
    wr(12'h320, 2'b00, 32'h7);
    rd(12'hB00, 102, "cy_frozen_a");
    rd(12'hB02, 52, "ir_frozen_a");
    rd(12'h320, 5, "mcntinh_bit1");
    repeat (5) @(posedge i_clk);
    #1 rd(12'hB00, 102, "cy_frozen_b");
    rd(12'hB02, 52, "ir_frozen_b");
    wr(12'h320, 2'b10, 32'h1);
    rd(12'hC00, 102, "cy_resume_a");
    rd(12'hC00, 103, "cy_resume_b");
    rd(12'hC02, 52, "ir_still_frozen");
    rd(12'h320, 4, "mcntinh_rc");
    wr(12'h320, 2'b00, 32'h0);
    rd(12'hC02, 52, "ir_resume_a");
    rd(12'hC02, 54, "ir_resume_b");
    i_instret_cnt = 2'd0;
    wr(12'hB02, 2'b00, 32'hFFFF_FFFF);
    wr(12'hB82, 2'b00, 32'hFFFF_FFFF);
    i_instret_cnt = 2'd2;
    rd(12'hC82, 32'hFFFF_FFFF, "instreth_max");
    i_instret_cnt = 2'd0;
    rd(12'hB02, 1, "minstret_wrap_lo");
    rd(12'hB82, 0, "minstret_wrap_hi");
    i_csr_addr = 12'h7C0; i_csr_op = 2'b00;
    chk("unmapped_illegal", 1, 1);
    chk("unmapped_rd0", 0, 0);
    sample();
    i_csr_addr = 12'h003; i_csr_op = 2'b11;
    chk("op11_illegal", 1, 1);
    chk("op11_rd0", 0, 0);
    sample();
    i_csr_op = 2'b00;
    chk("legal_not_illegal", 1, 0);
    chk("fcsr_before_rst", 0, 32'h77);
    sample();
    i_csr_addr = 12'h003; i_csr_op = 2'b01; i_wr_data = 32'hFF; i_csr_write = 1'b1;
    #2 i_rst_n = 1'b0;
    @(posedge i_clk);
    #1 i_csr_write = 1'b0; i_rst_n = 1'b1;
    rd(12'hC00, 0, "rst2_cycle");
    chk("rst2_frm", 2, 0);
    rd(12'h003, 0, "rst2_fcsr");
    rd(12'h320, 0, "rst2_mcntinh");
    @(negedge i_clk);
    done = 1'b1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
